// File: rtl/toggle_pkg.sv
// Shared types and constants for the toggle burst decoder.
package toggle_pkg;

  // Burst FSM: wait for a toggle, count a burst, hold the result for the consumer.
  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StHold
  } state_e;

  // Idle counter width; holds the largest legal IDLE_CYCLES (255).
  localparam int unsigned IdleCntW = 8;

endpackage

// File: rtl/toggle_burst_decoder_if.sv
// Toggle input and burst-result handshake bundle for toggle_burst_decoder.
interface toggle_burst_decoder_if #(
  parameter int unsigned CNT_W = 8
);

  logic             Tin;
  logic             Ready;
  logic             Event;
  logic             Valid;
  logic [CNT_W-1:0] Count;
  logic             Overflow;
  logic             Dropped;

  // Drives the toggle line and consumes results.
  modport master (
    output Tin,
    output Ready,
    input  Event,
    input  Valid,
    input  Count,
    input  Overflow,
    input  Dropped
  );

  // The decoder side.
  modport slave (
    input  Tin,
    input  Ready,
    output Event,
    output Valid,
    output Count,
    output Overflow,
    output Dropped
  );

endinterface

// File: rtl/toggle_edge_detect.sv
// Detects level changes on the toggle line and emits a registered one-cycle pulse per change.
module toggle_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tin_i,
  output logic toggle_o,
  output logic event_o
);

  logic t_q;
  logic event_q;

  // t_q follows tin_i even during reset so releasing reset never looks like a toggle.
  always_ff @(posedge clk_i) begin
    t_q <= tin_i;
    if (rst_i) begin
      event_q <= 1'b0;
    end else begin
      event_q <= toggle_o;
    end
  end

  assign toggle_o = (tin_i != t_q);
  assign event_o  = event_q;

endmodule

// File: rtl/toggle_burst_decoder.sv
// Turns toggles on a level line into event pulses and reports burst lengths on valid/ready.
module toggle_burst_decoder
  import toggle_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned IDLE_CYCLES = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  toggle_burst_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0]    CntMax    = '1;
  localparam logic [CNT_W-1:0]    CntOne    = CNT_W'(1);
  localparam logic [IdleCntW-1:0] IdleLimit = IdleCntW'(IDLE_CYCLES);

  logic toggle;
  logic event_q;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IdleCntW-1:0] idle_q, idle_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;
  logic                dropped_q, dropped_d;

  toggle_edge_detect u_edge (
    .clk_i    (Clock),
    .rst_i    (Reset),
    .tin_i    (bus.Tin),
    .toggle_o (toggle),
    .event_o  (event_q)
  );

  // State and result registers; reset discards any burst in progress.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      idle_q    <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  // Next-state: count toggles, close the burst after IDLE_CYCLES quiet edges, hold until taken.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    dropped_d = dropped_q;
    unique case (state_q)
      StIdle: begin
        if (toggle) begin
          state_d = StBurst;
          cnt_d   = CntOne;
          idle_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      StBurst: begin
        if (toggle) begin
          idle_d = '0;
          if (cnt_q == CntMax) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end else begin
          idle_d = idle_q + IdleCntW'(1);
          if (idle_d == IdleLimit) begin
            state_d = StHold;
            valid_d = 1'b1;
          end
        end
      end
      StHold: begin
        if (valid_q && bus.Ready) begin
          valid_d = 1'b0;
          ovf_d   = 1'b0;
          idle_d  = '0;
          // A toggle on the handshake edge starts the next burst rather than being lost.
          if (toggle) begin
            state_d = StBurst;
            cnt_d   = CntOne;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end else if (toggle) begin
          dropped_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.Event    = event_q;
  assign bus.Valid    = valid_q;
  assign bus.Count    = cnt_q;
  assign bus.Overflow = ovf_q;
  assign bus.Dropped  = dropped_q;

endmodule

// File: tb/tb_toggle_burst_decoder.sv
// Randomized and directed bench for toggle_burst_decoder; two instances (CNT_W 8 and 4) share stimulus.
module tb_toggle_burst_decoder;

  logic Clock;
  logic Reset;

  toggle_burst_decoder_if #(.CNT_W(8)) bus8 ();
  toggle_burst_decoder_if #(.CNT_W(4)) bus4 ();

  toggle_burst_decoder #(
    .CNT_W       (8),
    .IDLE_CYCLES (4)
  ) u_dut8 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus8)
  );

  toggle_burst_decoder #(
    .CNT_W       (4),
    .IDLE_CYCLES (4)
  ) u_dut4 (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus4)
  );

  localparam int Idle = 4;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: unbounded burst length, saturation applied only when the result is read.
  bit m_prev;
  bit m_event;
  bit m_in   [2];
  bit m_pend [2];
  bit m_drop [2];
  int m_len  [2];
  int m_quiet[2];
  int m_res  [2];
  int m_max  [2];

  logic tin;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic t, input logic r, input logic rst);
    bit tog;
    if (rst) begin
      m_prev  = t;
      m_event = 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_in[i]    = 1'b0;
        m_pend[i]  = 1'b0;
        m_drop[i]  = 1'b0;
        m_len[i]   = 0;
        m_quiet[i] = 0;
        m_res[i]   = 0;
      end
    end else begin
      tog     = (t != m_prev);
      m_prev  = t;
      m_event = tog;
      for (int i = 0; i < 2; i++) begin
        if (m_pend[i]) begin
          if (r) begin
            m_pend[i] = 1'b0;
            if (tog) begin
              m_in[i]    = 1'b1;
              m_len[i]   = 1;
              m_quiet[i] = 0;
            end
          end else if (tog) begin
            m_drop[i] = 1'b1;
          end
        end else if (m_in[i]) begin
          if (tog) begin
            m_len[i]++;
            m_quiet[i] = 0;
          end else begin
            m_quiet[i]++;
            if (m_quiet[i] == Idle) begin
              m_pend[i] = 1'b1;
              m_res[i]  = m_len[i];
              m_in[i]   = 1'b0;
            end
          end
        end else if (tog) begin
          m_in[i]    = 1'b1;
          m_len[i]   = 1;
          m_quiet[i] = 0;
        end
      end
    end
  endtask

  task automatic check_inst(input int i, input logic ev, input logic vld, input int unsigned cnt,
                            input logic ovf, input logic drp, input logic rst);
    int unsigned exp_cnt;
    check_eq($sformatf("d%0d.event", i), ev, m_event);
    check_eq($sformatf("d%0d.valid", i), vld, m_pend[i]);
    check_eq($sformatf("d%0d.dropped", i), drp, m_drop[i]);
    if (m_pend[i]) begin
      exp_cnt = (m_res[i] > m_max[i]) ? m_max[i] : m_res[i];
      check_eq($sformatf("d%0d.count", i), cnt, exp_cnt);
      check_eq($sformatf("d%0d.overflow", i), ovf, (m_res[i] > m_max[i]) ? 1 : 0);
    end
    if (rst) begin
      check_eq($sformatf("d%0d.rst_count", i), cnt, 0);
      check_eq($sformatf("d%0d.rst_overflow", i), ovf, 0);
    end
  endtask

  // Apply inputs, clock once, advance the model and compare just after the edge.
  task automatic step(input logic t, input logic r, input logic rst);
    bus8.Tin   = t;
    bus4.Tin   = t;
    bus8.Ready = r;
    bus4.Ready = r;
    Reset      = rst;
    @(posedge Clock);
    model_step(t, r, rst);
    #1;
    check_inst(0, bus8.Event, bus8.Valid, 32'(bus8.Count), bus8.Overflow, bus8.Dropped, rst);
    check_inst(1, bus4.Event, bus4.Valid, 32'(bus4.Count), bus4.Overflow, bus4.Dropped, rst);
  endtask

  task automatic quiet(input int n, input logic r);
    for (int k = 0; k < n; k++) step(tin, r, 1'b0);
  endtask

  task automatic flip(input logic r);
    tin = ~tin;
    step(tin, r, 1'b0);
  endtask

  initial begin
    int   p;
    logic r;
    logic rs;
    m_max[0] = 255;
    m_max[1] = 15;
    tin = 1'b1;

    // Reset with the line high, then a long quiet stretch: no events, no result.
    step(tin, 1'b0, 1'b1);
    step(tin, 1'b0, 1'b1);
    quiet(10, 1'b0);

    // Three back-to-back toggles, consumer always ready.
    flip(1'b1);
    flip(1'b1);
    flip(1'b1);
    quiet(8, 1'b1);

    // Seventeen spaced toggles: saturates and overflows the narrow instance.
    for (int k = 0; k < 17; k++) begin
      flip(1'b0);
      quiet(1, 1'b0);
    end
    quiet(6, 1'b0);
    quiet(2, 1'b1);

    // Result held with Ready low; a toggle during the hold is dropped.
    step(tin, 1'b0, 1'b1);
    flip(1'b0);
    flip(1'b0);
    quiet(6, 1'b0);
    flip(1'b0);
    quiet(3, 1'b0);
    quiet(2, 1'b1);

    // Handshake on the same edge as a toggle starts a new one-toggle burst.
    flip(1'b0);
    quiet(5, 1'b0);
    flip(1'b1);
    quiet(6, 1'b0);
    quiet(2, 1'b1);

    // Reset two cycles into a burst discards it.
    flip(1'b0);
    flip(1'b0);
    step(tin, 1'b0, 1'b1);
    quiet(8, 1'b1);

    // Random traffic alternating busy and sparse phases with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      p  = ((k / 200) % 2 != 0) ? 15 : 60;
      if ($urandom_range(0, 99) < p) tin = ~tin;
      r  = ($urandom_range(0, 99) < 50);
      rs = ($urandom_range(0, 999) < 5);
      step(tin, r, rs);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
